// File: rtl/p3p_pkg.sv
// p3p_pkg: shared types and constants for the score transmit path.
//
// Contents:
//   num              - signed 16-bit score value.
//   tx_state_t       - UART serialiser states (IDLE, START, DATA, STOP).
//   SCORE_SYNC_BYTE  - record prefix byte. It is used only when SCORE_TX_SYNC_EN
//                      is defined.
//   IDX_W / SCORE_W / REC_W - widths of the fields in a result record.
package p3p_pkg;

    typedef logic signed [15:0] num;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] SCORE_SYNC_BYTE = 8'hA5;

    localparam int IDX_W   = 8;
    localparam int SCORE_W = 16;
    localparam int REC_W   = IDX_W + SCORE_W;  // {senone_idx, senone_score}

endpackage

// File: rtl/score_fifo.sv
// score_fifo: single-clock synchronous FIFO that holds result records.
//
// A record can be written in the same cycle that one is read while the FIFO is
// full. The pop frees a slot, so the push is accepted.
// The read data is combinational from the head entry. The serialiser loads the
// record into its shift register on the same edge that it pops the record.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-low reset
//   push     in   write wr_data (accepted when not full, or when popping)
//   wr_data  in   record to write
//   pop      in   discard the head entry (ignored when empty)
//   rd_data  out  head entry
//   full     out  DEPTH entries held
//   empty    out  no entries held
//   level    out  number of entries held
module score_fifo
    import p3p_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = REC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign level   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so the pointers wrap without extra logic.
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The storage is not reset. Entries are only read after they have been written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/score_uart_tx.sv
// score_uart_tx: queues senone results and sends each one as a byte record over
// an 8N1 UART line.
//
// Record byte order: senone_idx, senone_score[15:8], senone_score[7:0].
// When SCORE_TX_SYNC_EN is defined, the sync byte 0xA5 is sent before each
// record, which gives a 4-byte record.
// Each frame is one start bit (0), eight data bits sent LSB first, and one stop
// bit (1). Each bit lasts CLK_FREQ/BAUD clock cycles.
// Bytes and records are sent back to back with no idle time between them.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-low reset
//   score_ready   in   strobe: senone_idx/senone_score are valid in this cycle
//   senone_idx    in   senone index
//   senone_score  in   signed score
//   tx            out  UART serial output, idle high
//   busy          out  FIFO non-empty or a frame in flight
//   overflow      out  sticky: a result was dropped because the FIFO was full
//   fifo_level    out  records queued, not counting the record in flight
module score_uart_tx
    import p3p_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          score_ready,
    input  logic [7:0]                    senone_idx,
    input  logic [15:0]                   senone_score,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BIT_PERIOD = CLK_FREQ / BAUD;
    localparam int BAUD_W     = $clog2(BIT_PERIOD + 1);

`ifdef SCORE_TX_SYNC_EN
    localparam int         SHIFT_W   = REC_W + 8;
    localparam logic [1:0] LAST_BYTE = 2'd3;
`else
    localparam int         SHIFT_W   = REC_W;
    localparam logic [1:0] LAST_BYTE = 2'd2;
`endif

    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]        byte_sel_q, byte_sel_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;

    num                score_in;
    logic [REC_W-1:0]  fifo_rd;
    logic [SHIFT_W-1:0] load_val;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              bit_end;
    logic [7:0]        cur_byte_d;

    assign score_in = senone_score;

    score_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (score_ready),
        .wr_data ({senone_idx, score_in}),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

`ifdef SCORE_TX_SYNC_EN
    assign load_val = {SCORE_SYNC_BYTE, fifo_rd};
`else
    assign load_val = fifo_rd;
`endif

    assign bit_end = (baud_cnt_q == BAUD_W'(BIT_PERIOD - 1));

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_sel_d = byte_sel_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        // The baud counter restarts at the start of every bit. It is held at
        // zero while idle, so the first bit after idle is also full length.
        baud_cnt_d = (state_q == IDLE || bit_end) ? '0 : baud_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_d    = load_val;
                    byte_sel_d = 2'd0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_sel_q != LAST_BYTE) begin
                        byte_sel_d = byte_sel_q + 1'b1;
                        shift_d    = shift_q << 8;
                        state_d    = START;
                    end else if (!fifo_empty) begin
                        // Start the next record straight after this stop bit.
                        pop        = 1'b1;
                        shift_d    = load_val;
                        byte_sel_d = 2'd0;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is taken from the next state. This keeps tx
        // registered and aligned to the state change.
        cur_byte_d = shift_d[SHIFT_W-1 -: 8];
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte_d[bit_cnt_d];
            default: tx_d = 1'b1;
        endcase

        // The FIFO is not popped while the next state is IDLE. So the only
        // change to its level is a push in this cycle.
        busy_d     = (state_d != IDLE) | ~fifo_empty | score_ready;
        overflow_d = overflow_q | (score_ready & fifo_full & ~pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            byte_sel_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_sel_q <= byte_sel_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_score_uart_tx.sv
// tb_score_uart_tx: self-checking bench for score_uart_tx.
// Expected record bytes are pushed to a queue when a strobe is driven. A line
// monitor decodes each UART frame and compares it with the head of that queue.
// The monitor also checks that every bit lasts exactly BIT cycles.
// SCORE_TX_SYNC_EN selects a 4-byte record, otherwise a 3-byte record.
module tb_score_uart_tx;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 2_500_000;
    localparam int BIT      = CLK_FREQ / BAUD;   // 20 cycles per bit
    localparam int DEPTH    = 16;
`ifdef SCORE_TX_SYNC_EN
    localparam int REC_BYTES = 4;
`else
    localparam int REC_BYTES = 3;
`endif
    localparam int FRAME_CYC = 10 * BIT;
    localparam int REC_CYC   = REC_BYTES * FRAME_CYC;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      score_ready;
    logic [7:0]                senone_idx;
    logic [15:0]               senone_score;
    logic                      tx;
    logic                      busy;
    logic                      overflow;
    logic [$clog2(DEPTH):0]    fifo_level;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int lvl_max     = 0;
    logic [7:0] exp_q[$];
    int         fs_q[$];

    score_uart_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .score_ready  (score_ready),
        .senone_idx   (senone_idx),
        .senone_score (senone_score),
        .tx           (tx),
        .busy         (busy),
        .overflow     (overflow),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [7:0] idx, input logic [15:0] sc);
`ifdef SCORE_TX_SYNC_EN
        exp_q.push_back(8'hA5);
`endif
        exp_q.push_back(idx);
        exp_q.push_back(sc[15:8]);
        exp_q.push_back(sc[7:0]);
    endtask

    task automatic strobe(input logic [7:0] idx, input logic [15:0] sc);
        @(posedge clk); #1;
        senone_idx   = idx;
        senone_score = sc;
        score_ready  = 1'b1;
        @(posedge clk); #1;
        score_ready  = 1'b0;
    endtask

    task automatic wait_tx_low(input string tag);
        int n = 0;
        while (tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        check(tag, {31'd0, tx}, 32'd0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    // Line monitor: decodes one frame per falling start edge.
    initial begin : monitor
        logic [7:0] got;
        logic [7:0] expb;
        logic       first_lvl;
        int         bad;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) begin
                fs_q.push_back(cyc);
                got = '0; bad = 0; aborted = 0; first_lvl = 1'b0;
                for (int off = 1; off < FRAME_CYC; off++) begin
                    @(negedge clk);
                    if (reset !== 1'b1) begin aborted = 1; break; end
                    if (off % BIT == 0) first_lvl = tx;
                    else if (tx !== first_lvl) bad++;
                    if (off / BIT >= 1 && off / BIT <= 8 && off % BIT == BIT / 2)
                        got[off / BIT - 1] = tx;
                    if (off / BIT == 9 && tx !== 1'b1) bad++;
                end
                if (!aborted) begin
                    check("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        expb = exp_q.pop_front();
                        check("frame_byte", {24'd0, got}, {24'd0, expb});
                    end
                    check("frame_timing_bad_cycles", bad, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t0;
        int tfall;
        int target;
        int gap_bad;
        int low_cnt;
        int busy_cnt;

        reset = 1'b0; score_ready = 1'b0; senone_idx = '0; senone_score = '0;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        check("reset_level", fifo_level, 0);
        reset = 1'b1;

        // 1: single record into an idle block
        fs_q.delete();
        push_exp(8'h03, 16'h1234);
        @(posedge clk); #1;
        t0 = cyc;
        senone_idx = 8'h03; senone_score = 16'h1234; score_ready = 1'b1;
        @(posedge clk); #1;
        score_ready = 1'b0;
        @(negedge clk);
        check("t1_level_after_push", fifo_level, 1);
        check("t1_busy_after_push", {31'd0, busy}, 32'd1);
        wait_tx_low("t1_tx_fall");
        check("t1_latency", cyc - t0, 2);
        tfall = cyc;
        wait_idle("t1_idle", REC_CYC + 100);
        check("t1_busy_duration", cyc - tfall, REC_CYC);
        check("t1_overflow", {31'd0, overflow}, 32'd0);
        check("t1_queue_drained", exp_q.size(), 0);

        // 2: negative score
        push_exp(8'hFF, 16'hFFFE);
        strobe(8'hFF, 16'hFFFE);
        wait_idle("t2_idle", REC_CYC + 100);
        check("t2_queue_drained", exp_q.size(), 0);

        // 3: five consecutive strobes, must go out with no gaps
        fs_q.delete();
        lvl_max = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            push_exp(8'(i), 16'(16'h0100 * i + 16'h0055));
            senone_idx = 8'(i); senone_score = 16'(16'h0100 * i + 16'h0055);
            score_ready = 1'b1;
            @(posedge clk); #1;
        end
        score_ready = 1'b0;
        wait_idle("t3_idle", 5 * REC_CYC + 100);
        check("t3_level_peak", lvl_max, 4);
        check("t3_frames", fs_q.size(), 5 * REC_BYTES);
        gap_bad = 0;
        for (int i = 1; i < fs_q.size(); i++)
            if (fs_q[i] - fs_q[i-1] != FRAME_CYC) gap_bad++;
        check("t3_gaps", gap_bad, 0);
        check("t3_queue_drained", exp_q.size(), 0);

        // 4: overflow, 18 strobes while the first record is in flight
        fs_q.delete();
        lvl_max = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 18; i++) begin
            if (i == 17) begin
                check("t4_level_full", fifo_level, DEPTH);
                check("t4_no_overflow_yet", {31'd0, overflow}, 32'd0);
            end
            if (i != 17) push_exp(8'(8'h40 + i), {8'(i), 8'(~i)});
            senone_idx = 8'(8'h40 + i); senone_score = {8'(i), 8'(~i)};
            score_ready = 1'b1;
            @(posedge clk); #1;
        end
        score_ready = 1'b0;
        check("t4_overflow_set", {31'd0, overflow}, 32'd1);
        wait_idle("t4_idle", 18 * REC_CYC + 100);
        check("t4_level_peak", lvl_max, DEPTH);
        check("t4_frames", fs_q.size(), 17 * REC_BYTES);
        check("t4_queue_drained", exp_q.size(), 0);
        repeat (20) @(negedge clk);
        check("t4_overflow_sticky", {31'd0, overflow}, 32'd1);

        // 5: reset during DATA bit 3 of byte_sel 2 (a 0 bit)
        push_exp(8'h77, 16'h1200);
        strobe(8'h77, 16'h1200);
        @(negedge clk);
        wait_tx_low("t5_tx_fall");
        tfall = cyc;
        target = tfall + (REC_BYTES - 1) * FRAME_CYC + 4 * BIT + BIT / 2;
        while (cyc < target) @(negedge clk);
        check("t5_tx_before_reset", {31'd0, tx}, 32'd0);
        #2 reset = 1'b0;
        #1;
        check("t5_tx_async", {31'd0, tx}, 32'd1);
        check("t5_busy_async", {31'd0, busy}, 32'd0);
        check("t5_overflow_cleared", {31'd0, overflow}, 32'd0);
        check("t5_level_cleared", fifo_level, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        low_cnt = 0; busy_cnt = 0;
        repeat (5 * FRAME_CYC) begin
            @(negedge clk);
            if (tx !== 1'b1) low_cnt++;
            if (busy !== 1'b0) busy_cnt++;
        end
        check("t5_tx_stays_idle", low_cnt, 0);
        check("t5_busy_stays_low", busy_cnt, 0);

        // 6: record 0x01 / 0x0080
        push_exp(8'h01, 16'h0080);
        strobe(8'h01, 16'h0080);
        @(negedge clk);
        wait_tx_low("t6_tx_fall");
        tfall = cyc;
        wait_idle("t6_idle", REC_CYC + 100);
        check("t6_busy_duration", cyc - tfall, REC_CYC);
        check("t6_queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/score_uart_tx.md
Name: score_uart_tx

Overview:
- Transmit-direction counterpart of the feature-vector receive path.
- Accepts (senone_idx, senone_score) results from the GDP controller and buffers them in a small FIFO.
- Serialises each result as a fixed byte record over an 8N1 UART line back to L'Imperatrice.
- Sits beside gdp_controller at top level and replaces the fixed two-byte tx buffer handshake.

Parameters:
clk_freq, 50000000, input clock frequency in Hz
baud, 115200, line rate; bit period = clk_freq/baud cycles (integer division; 434 at defaults)
fifo_depth, 16, number of result records buffered; power of two, >= 2

Ports:
clk  input  1  system clock (50 MHz)
reset  input  1  asynchronous, active-low reset
score_ready  input  1  single-cycle strobe: senone_idx/senone_score valid this cycle
senone_idx  input  8  senone index of the result
senone_score  input  16  signed score, num format
tx  output  1  UART serial out, idle high
busy  output  1  high while FIFO non-empty or a frame is in flight
overflow  output  1  sticky: a result was dropped because the FIFO was full
fifo_level  output  $clog2(fifo_depth)+1  records currently queued, excluding the record in flight

Behaviour:
- Reset (reset=0, async): tx=1, busy=0, overflow=0, fifo_level=0, FIFO pointers cleared, FSM=IDLE, baud counter=0. Any frame in progress is abandoned immediately; tx returns high.
- Push: score_ready=1 and FIFO not full -> record {idx, score} written; fifo_level increments next cycle.
- Full FIFO:
  - score_ready with no pop in the same cycle -> record dropped; overflow set and held until reset.
  - Push and pop in the same cycle while full -> push accepted; level unchanged.
- Record bytes, in order: senone_idx, senone_score[15:8], senone_score[7:0].
- Frame: start bit 0, data bits LSB first, stop bit 1. Each bit held exactly clk_freq/baud cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when the FIFO is non-empty. The head record is popped into a 24-bit shift register, byte_sel=0, and tx goes low on the following cycle.
  - START -> DATA after one bit period; bit_cnt=0.
  - DATA -> STOP after 8 bit periods; bit_cnt wraps 7->0.
  - STOP, after one bit period:
    - byte_sel<2 -> START with the next byte, no idle gap.
    - byte_sel==2 and FIFO non-empty -> immediate pop and START; back-to-back records have no gap.
    - Otherwise -> IDLE.
- Latency: score_ready into an empty idle block -> tx falls 2 cycles later.
- Record duration: 30 bit periods = 13020 cycles at defaults.
- busy = (state!=IDLE) | (fifo_level!=0), registered.
- No flow control input; the consumer must keep up or overflow is flagged.

Optional Feature:
- Macro: SCORE_TX_SYNC_EN.
- Defined: every record is prefixed with sync byte 0xA5, giving a 4-byte record. byte_sel runs 0..3 and record duration is 40 bit periods.
- Undefined: 3-byte record exactly as above; no sync logic is synthesised.

Decomposition:
- Shared package p3p_pkg:
  - num typedef (logic signed [15:0]).
  - tx_state_t enum {IDLE, START, DATA, STOP}.
  - SCORE_SYNC_BYTE constant 8'hA5.
  - Record width constants.
- One sub-module, score_fifo: synchronous single-clock FIFO.
  - Width 24, depth fifo_depth.
  - Ports: push, pop, full, empty, level.
  - Same async active-low reset.
- The serialiser FSM and baud counter stay in score_uart_tx.

Test Plan:
- Single record: idx=0x03, score=0x1234 into idle block -> tx decodes bytes 0x03, 0x12, 0x34; each bit 434 cycles; busy falls 13020 cycles after tx first falls; overflow=0.
- Negative score: idx=0xFF, score=-2 -> bytes 0xFF, 0xFF, 0xFE.
- Back-to-back: 5 strobes 1 cycle apart (idx 0..4) -> 15 frames with no idle bit between stop and next start; fifo_level peaks at 4; final order idx 0..4.
- Overflow: 18 strobes while the first record transmits -> first record plus 16 queued records sent, 1 dropped; overflow=1 until reset; level never exceeds 16.
- Reset mid-frame: assert reset during DATA bit 3 of byte 2 -> tx=1 within the same cycle (async); after release with no strobes, tx stays high and busy=0.
- With SCORE_TX_SYNC_EN: idx=0x01, score=0x0080 -> bytes 0xA5, 0x01, 0x00, 0x80; record lasts 17360 cycles.
